// File: rtl/mips8_controller_pkg.sv
// Shared types and encodings for the miniMIPS 8-bit multicycle controller.
// Opcodes, funct codes, ALU operation codes and datapath mux selects live here.
package mips8_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH_A,
        S_FETCH_B,
        S_DECODE,
        S_MEM_A,
        S_MEM_B,
        S_LB_RD,
        S_LB_WR,
        S_SB_WR,
        S_RT_A,
        S_RT_B,
        S_RT_WR,
        S_BEQ_A,
        S_BEQ_B,
        S_BEQ_C,
        S_BEQ_D,
        S_J_EX
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic       MUX2_PC    = 1'b0;
    localparam logic       MUX2_REGA  = 1'b1;
    localparam logic [1:0] MUX4_REGB  = 2'b00;
    localparam logic [1:0] MUX4_ONE   = 2'b01;
    localparam logic [1:0] MUX4_IMM   = 2'b10;
    localparam logic [1:0] MUX4_IMMX4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips8_controller_if.sv
// Control interface between the miniMIPS controller (master) and its datapath (slave).
interface mips8_controller_if #(parameter int IR_BYTES = 4);

    logic [5:0]          op;
    logic [5:0]          funct;
    logic                zero_in;
    logic                mux2_cntrl;
    logic [1:0]          mux4_cntrl;
    logic [2:0]          alu_cntrl;
    logic                srcA_cntrl;
    logic                srcB_cntrl;
    logic                aluout_cntrl;
    logic                memread;
    logic                memwrite;
    logic                iord;
    logic [IR_BYTES-1:0] irwrite;
    logic                regwrite;
    logic                regdst;
    logic                memtoreg;
    logic                pcen;
    logic [1:0]          pcsrc;

    modport master (
        input  op, funct, zero_in,
        output mux2_cntrl, mux4_cntrl, alu_cntrl, srcA_cntrl, srcB_cntrl,
               aluout_cntrl, memread, memwrite, iord, irwrite, regwrite,
               regdst, memtoreg, pcen, pcsrc
    );

    modport slave (
        output op, funct, zero_in,
        input  mux2_cntrl, mux4_cntrl, alu_cntrl, srcA_cntrl, srcB_cntrl,
               aluout_cntrl, memread, memwrite, iord, irwrite, regwrite,
               regdst, memtoreg, pcen, pcsrc
    );

endinterface

// File: rtl/mips8_controller_alu_decoder.sv
// Combinational ALU decoder: forced add/sub, or an R-type funct lookup.
// Unrecognised funct codes fall back to add so the instruction still writes back.
module mips8_alu_decoder
    import mips8_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    input  aluop_t     i_aluop,
    output logic [2:0] o_alu_cntrl
);

    always_comb begin
        o_alu_cntrl = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB: o_alu_cntrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_cntrl = ALU_ADD;
                    FN_SUB:  o_alu_cntrl = ALU_SUB;
                    FN_AND:  o_alu_cntrl = ALU_AND;
                    FN_OR:   o_alu_cntrl = ALU_OR;
                    FN_SLT:  o_alu_cntrl = ALU_SLT;
                    default: o_alu_cntrl = ALU_ADD;
                endcase
            end
            default: o_alu_cntrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips8_controller.sv
// Multicycle control unit for the 8-bit miniMIPS core: byte-wise fetch, decode,
// and sequencing of the ALU datapath, memory, register file and PC.
module mips8_controller
    import mips8_ctrl_pkg::*;
#(
    parameter int IR_BYTES = 4
) (
    input  logic          clk,
    input  logic          rst,
    mips8_controller_if.master bus
);

    localparam int             CNT_W    = (IR_BYTES > 1) ? $clog2(IR_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IR_BYTES - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    aluop_t              w_aluOp;
    logic [2:0]          w_aluCntrl;
    logic [IR_BYTES-1:0] w_irwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH_A;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH_A: r_state <= S_FETCH_B;
                S_FETCH_B: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DECODE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_FETCH_A;
                    end
                end
                S_DECODE: begin
                    case (bus.op)
                        OP_LB, OP_SB: r_state <= S_MEM_A;
                        OP_RTYPE:     r_state <= S_RT_A;
                        OP_BEQ:       r_state <= S_BEQ_A;
                        OP_J:         r_state <= S_J_EX;
                        default:      r_state <= S_FETCH_A;
                    endcase
                end
                S_MEM_A: r_state <= S_MEM_B;
                S_MEM_B: r_state <= (bus.op == OP_LB) ? S_LB_RD : S_SB_WR;
                S_LB_RD: r_state <= S_LB_WR;
                S_RT_A:  r_state <= S_RT_B;
                S_RT_B:  r_state <= S_RT_WR;
                S_BEQ_A: r_state <= S_BEQ_B;
                S_BEQ_B: r_state <= S_BEQ_C;
                S_BEQ_C: r_state <= bus.zero_in ? S_BEQ_D : S_FETCH_A;
                default: r_state <= S_FETCH_A;
            endcase
        end
    end

    mips8_alu_decoder u_aluDecoder (
        .i_funct     (bus.funct),
        .i_aluop     (w_aluOp),
        .o_alu_cntrl (w_aluCntrl)
    );

    assign w_irwrite     = IR_BYTES'(1) << r_cnt;
    assign bus.alu_cntrl = w_aluCntrl;

    // Outputs follow the state register; the zero flag only gates the branch-target capture.
    always_comb begin
        w_aluOp          = ALUOP_ADD;
        bus.mux2_cntrl   = MUX2_PC;
        bus.mux4_cntrl   = MUX4_REGB;
        bus.srcA_cntrl   = 1'b0;
        bus.srcB_cntrl   = 1'b0;
        bus.aluout_cntrl = 1'b0;
        bus.memread      = 1'b0;
        bus.memwrite     = 1'b0;
        bus.iord         = 1'b0;
        bus.irwrite      = '0;
        bus.regwrite     = 1'b0;
        bus.regdst       = 1'b0;
        bus.memtoreg     = 1'b0;
        bus.pcen         = 1'b0;
        bus.pcsrc        = PCSRC_ALU;
        if (!rst) begin
            case (r_state)
                S_FETCH_A: begin
                    bus.memread    = 1'b1;
                    bus.irwrite    = w_irwrite;
                    bus.srcA_cntrl = 1'b1;
                    bus.srcB_cntrl = 1'b1;
                    bus.mux4_cntrl = MUX4_ONE;
                end
                S_FETCH_B, S_BEQ_D: bus.pcen = 1'b1;
                S_MEM_A: begin
                    bus.srcA_cntrl = 1'b1;
                    bus.srcB_cntrl = 1'b1;
                    bus.mux2_cntrl = MUX2_REGA;
                    bus.mux4_cntrl = MUX4_IMM;
                end
                S_MEM_B: bus.aluout_cntrl = 1'b1;
                S_LB_RD: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_LB_WR: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                S_SB_WR: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_RT_A, S_BEQ_A: begin
                    w_aluOp        = (r_state == S_RT_A) ? ALUOP_FUNCT : ALUOP_SUB;
                    bus.srcA_cntrl = 1'b1;
                    bus.srcB_cntrl = 1'b1;
                    bus.mux2_cntrl = MUX2_REGA;
                end
                S_RT_B, S_BEQ_B: begin
                    w_aluOp          = (r_state == S_RT_B) ? ALUOP_FUNCT : ALUOP_SUB;
                    bus.aluout_cntrl = 1'b1;
                end
                S_RT_WR: begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 1'b1;
                end
                S_BEQ_C: begin
                    if (bus.zero_in) begin
                        bus.srcA_cntrl = 1'b1;
                        bus.srcB_cntrl = 1'b1;
                        bus.mux4_cntrl = MUX4_IMMX4;
                    end
                end
                S_J_EX: begin
                    bus.pcen  = 1'b1;
                    bus.pcsrc = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips8_controller.sv
// Self-checking bench for mips8_controller: per-instruction expected output
// sequences are queued when an instruction is applied and popped every cycle.
module tb_mips8_controller;

    typedef struct packed {
        logic       mux2;
        logic [1:0] mux4;
        logic [2:0] alu;
        logic       srcA;
        logic       srcB;
        logic       aluout;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       pcen;
        logic [1:0] pcsrc;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [2:0] expAlu;
        string      name;
    } vec_t;

    typedef struct {
        ctrl_t exp;
        string name;
    } sb_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    testsRun = 0;
    int    testsFailed = 0;
    sb_t   sbQueue[$];
    vec_t  vectors[12];

    always #5 clk = ~clk;

    mips8_controller_if #(.IR_BYTES(4)) bus();

    mips8_controller #(.IR_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic ctrl_t dflt();
        ctrl_t c;
        c = '0;
        c.alu = 3'b010;
        return c;
    endfunction

    function automatic ctrl_t strobeMask();
        ctrl_t m;
        m = '0;
        m.srcA = 1'b1;
        m.srcB = 1'b1;
        m.aluout = 1'b1;
        m.memread = 1'b1;
        m.memwrite = 1'b1;
        m.irwrite = 4'b1111;
        m.regwrite = 1'b1;
        m.pcen = 1'b1;
        return m;
    endfunction

    function automatic ctrl_t sampleDut();
        ctrl_t c;
        c.mux2 = bus.mux2_cntrl;
        c.mux4 = bus.mux4_cntrl;
        c.alu = bus.alu_cntrl;
        c.srcA = bus.srcA_cntrl;
        c.srcB = bus.srcB_cntrl;
        c.aluout = bus.aluout_cntrl;
        c.memread = bus.memread;
        c.memwrite = bus.memwrite;
        c.iord = bus.iord;
        c.irwrite = bus.irwrite;
        c.regwrite = bus.regwrite;
        c.regdst = bus.regdst;
        c.memtoreg = bus.memtoreg;
        c.pcen = bus.pcen;
        c.pcsrc = bus.pcsrc;
        return c;
    endfunction

    task automatic checkOutput(input string name, input ctrl_t expected, input ctrl_t mask);
        ctrl_t got;
        got = sampleDut();
        testsRun++;
        if ((got & mask) != (expected & mask)) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h (mask %h)", name, got, expected, mask);
        end
    endtask

    task automatic pushExp(input ctrl_t c, input string base, inout int n);
        sb_t e;
        n++;
        e.exp = c;
        e.name = $sformatf("%s cycle %0d", base, n);
        sbQueue.push_back(e);
    endtask

    // Drive one instruction's fields and queue the expected output of every cycle.
    task automatic applyStimulus(input vec_t v);
        ctrl_t c;
        int n = 0;
        bus.op = v.op;
        bus.funct = v.funct;
        bus.zero_in = v.zero;
        for (int k = 0; k < 4; k++) begin
            c = dflt();
            c.memread = 1'b1;
            c.irwrite = 4'b0001 << k;
            c.srcA = 1'b1;
            c.srcB = 1'b1;
            c.mux4 = 2'b01;
            pushExp(c, v.name, n);
            c = dflt();
            c.pcen = 1'b1;
            pushExp(c, v.name, n);
        end
        pushExp(dflt(), v.name, n);
        case (v.op)
            6'b000000: begin
                c = dflt(); c.srcA = 1'b1; c.srcB = 1'b1; c.mux2 = 1'b1; c.alu = v.expAlu;
                pushExp(c, v.name, n);
                c = dflt(); c.aluout = 1'b1; c.alu = v.expAlu;
                pushExp(c, v.name, n);
                c = dflt(); c.regwrite = 1'b1; c.regdst = 1'b1;
                pushExp(c, v.name, n);
            end
            6'b100000, 6'b101000: begin
                c = dflt(); c.srcA = 1'b1; c.srcB = 1'b1; c.mux2 = 1'b1; c.mux4 = 2'b10;
                pushExp(c, v.name, n);
                c = dflt(); c.aluout = 1'b1;
                pushExp(c, v.name, n);
                if (v.op == 6'b100000) begin
                    c = dflt(); c.memread = 1'b1; c.iord = 1'b1;
                    pushExp(c, v.name, n);
                    c = dflt(); c.regwrite = 1'b1; c.memtoreg = 1'b1;
                    pushExp(c, v.name, n);
                end else begin
                    c = dflt(); c.memwrite = 1'b1; c.iord = 1'b1;
                    pushExp(c, v.name, n);
                end
            end
            6'b000100: begin
                c = dflt(); c.srcA = 1'b1; c.srcB = 1'b1; c.mux2 = 1'b1; c.alu = 3'b110;
                pushExp(c, v.name, n);
                c = dflt(); c.aluout = 1'b1; c.alu = 3'b110;
                pushExp(c, v.name, n);
                if (v.zero) begin
                    c = dflt(); c.srcA = 1'b1; c.srcB = 1'b1; c.mux4 = 2'b11;
                    pushExp(c, v.name, n);
                    c = dflt(); c.pcen = 1'b1;
                    pushExp(c, v.name, n);
                end else begin
                    pushExp(dflt(), v.name, n);
                end
            end
            6'b000010: begin
                c = dflt(); c.pcen = 1'b1; c.pcsrc = 2'b10;
                pushExp(c, v.name, n);
            end
            default: ;
        endcase
    endtask

    task automatic drain(input int maxCycles);
        sb_t e;
        for (int i = 0; i < maxCycles && sbQueue.size() > 0; i++) begin
            @(negedge clk);
            #1;
            e = sbQueue.pop_front();
            checkOutput(e.name, e.exp, '1);
        end
    endtask

    initial begin
        ctrl_t fetch0;
        vectors[0]  = '{6'b000010, 6'b000000, 1'b0, 3'b010, "J"};
        vectors[1]  = '{6'b000000, 6'b100000, 1'b0, 3'b010, "R add"};
        vectors[2]  = '{6'b000000, 6'b100010, 1'b0, 3'b110, "R sub"};
        vectors[3]  = '{6'b000000, 6'b100100, 1'b1, 3'b000, "R and"};
        vectors[4]  = '{6'b000000, 6'b100101, 1'b0, 3'b001, "R or"};
        vectors[5]  = '{6'b000000, 6'b101010, 1'b0, 3'b111, "R slt"};
        vectors[6]  = '{6'b000000, 6'b000111, 1'b0, 3'b010, "R unknown funct"};
        vectors[7]  = '{6'b100000, 6'b101010, 1'b0, 3'b010, "LB"};
        vectors[8]  = '{6'b101000, 6'b100010, 1'b1, 3'b010, "SB"};
        vectors[9]  = '{6'b000100, 6'b000000, 1'b1, 3'b010, "BEQ taken"};
        vectors[10] = '{6'b000100, 6'b000000, 1'b0, 3'b010, "BEQ not taken"};
        vectors[11] = '{6'b111111, 6'b000111, 1'b0, 3'b010, "unknown op"};

        bus.op = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset strobes", '0, strobeMask());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(vectors[i]);
            drain(20);
        end

        // Abandon an R-type instruction in RT_B with two reset cycles.
        @(posedge clk);
        #1;
        applyStimulus(vectors[5]);
        drain(10);
        sbQueue.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset in RT_B", '0, strobeMask());
        @(negedge clk);
        #1;
        checkOutput("reset second cycle", '0, strobeMask());
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(vectors[0]);
        drain(20);

        @(posedge clk);
        #1;
        fetch0 = dflt();
        fetch0.memread = 1'b1;
        fetch0.irwrite = 4'b0001;
        fetch0.srcA = 1'b1;
        fetch0.srcB = 1'b1;
        fetch0.mux4 = 2'b01;
        @(negedge clk);
        #1;
        checkOutput("final FETCH_A", fetch0, '1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
